mac_host_arb: RTL and testbench

- Round-robin arbiter and sequencer for the Tri-Speed Ethernet MAC 8-bit host register bus (hcs_n/haddr/hdatain/hwrite_n/hread_n/hready_n/hdataout_en_n/hdataout).
- Lets NUM_REQ independent clients share one host port: boot-time configurator, statistics poller, runtime mode changes.
- Runs one single-byte read or write at a time and returns a one-cycle ack with read data per transaction.

---
 rtl/mac_host_arb_if.sv | 22 ++
 rtl/mac_host_arb.sv | 151 +++++++++++++++
 tb/tb_mac_host_arb.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_host_arb_if.sv
// Host register bus of the tri-speed MAC: one 8-bit single-byte access at a time.
// master = arbiter side, slave = MAC side.
interface mac_host_arb_if;
  logic       hcs_n;
  logic [7:0] haddr;
  logic [7:0] hdatain;
  logic       hwrite_n;
  logic       hread_n;
  logic       hready_n;
  logic       hdataout_en_n;
  logic [7:0] hdataout;

  modport master (
    output hcs_n, haddr, hdatain, hwrite_n, hread_n,
    input  hready_n, hdataout_en_n, hdataout
  );

  modport slave (
    input  hcs_n, haddr, hdatain, hwrite_n, hread_n,
    output hready_n, hdataout_en_n, hdataout
  );
endinterface

// File: rtl/mac_host_arb.sv
// Round-robin arbiter/sequencer sharing the MAC host register port among NUM_REQ clients.
// Optional access timeout when MAC_HOST_ARB_TIMEOUT_EN is defined (aborts with err and rdata=FF).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for bus_en and a request; picks the round-robin winner
// S_ACCESS  | hcs_n and one strobe low until hready_n (or timeout)
// S_ACK     | strobes released, ack/rdata/err pulse to the winner
// S_RECOVER | one quiet bus cycle, pointer advances, busy drops
module mac_host_arb #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   bus_en,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [NUM_REQ*8-1:0]   req_addr,
  input  logic [NUM_REQ*8-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             rdata,
  output logic                   err,
  output logic                   busy,
  mac_host_arb_if.master         host
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] cur;
  logic          cur_we;
  logic [7:0]    rd_cap;

  logic          found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          to_hit;

  // Scan from the highest offset down so the nearest requester after last_grant wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef MAC_HOST_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Counter is only ever entered from IDLE, so clearing there resets it on ACCESS entry.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      to_cnt <= '0;
    end else if (state == S_IDLE) begin
      to_cnt <= '0;
    end else if (state == S_ACCESS) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign to_hit = ((to_cnt + TW'(1)) == TW'(TIMEOUT_CYCLES));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= S_IDLE;
      last_grant    <= IW'(NUM_REQ - 1);
      cur           <= '0;
      cur_we        <= 1'b0;
      rd_cap        <= 8'h00;
      ack           <= '0;
      rdata         <= 8'h00;
      err           <= 1'b0;
      busy          <= 1'b0;
      host.hcs_n    <= 1'b1;
      host.hwrite_n <= 1'b1;
      host.hread_n  <= 1'b1;
      host.haddr    <= 8'h00;
      host.hdatain  <= 8'h00;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus_en && found) begin
            cur           <= win_idx;
            cur_we        <= req_we[win_idx];
            host.haddr    <= req_addr[{win_idx, 3'b000} +: 8];
            host.hdatain  <= req_wdata[{win_idx, 3'b000} +: 8];
            rd_cap        <= 8'h00;
            busy          <= 1'b1;
            host.hcs_n    <= 1'b0;
            host.hwrite_n <= ~req_we[win_idx];
            host.hread_n  <= req_we[win_idx];
            state         <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!host.hdataout_en_n) begin
            rd_cap <= host.hdataout;
          end
          if (!host.hready_n || to_hit) begin
            host.hcs_n    <= 1'b1;
            host.hwrite_n <= 1'b1;
            host.hread_n  <= 1'b1;
            ack[cur]      <= 1'b1;
            state         <= S_ACK;
            // Normal completion takes priority over a timeout in the same cycle.
            if (!host.hready_n) begin
              if (cur_we) begin
                rdata <= 8'h00;
              end else if (!host.hdataout_en_n) begin
                rdata <= host.hdataout;
              end else begin
                rdata <= rd_cap;
              end
            end else begin
              err   <= 1'b1;
              rdata <= 8'hFF;
            end
          end
        end
        S_ACK: begin
          state <= S_RECOVER;
        end
        default: begin
          busy       <= 1'b0;
          last_grant <= cur;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_host_arb.sv
// Directed bench for mac_host_arb with a small MAC host-bus responder.
// Define MAC_HOST_ARB_TIMEOUT_EN for both files to exercise the timeout path.
module tb_mac_host_arb;

  localparam int NR = 2;

  logic            clk;
  logic            arst_n;
  logic            bus_en;
  logic [NR-1:0]   req;
  logic [NR-1:0]   req_we;
  logic [NR*8-1:0] req_addr;
  logic [NR*8-1:0] req_wdata;
  logic [NR-1:0]   ack;
  logic [7:0]      rdata;
  logic            err;
  logic            busy;

  mac_host_arb_if hif ();

  mac_host_arb #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .bus_en    (bus_en),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .host      (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int multi_ack = 0;

  always @(negedge clk) begin
    if (arst_n && ($countones(ack) > 1)) multi_ack++;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for a grant, holds hready_n high until the strobe has been low for lat cycles,
  // optionally presents read data the cycle before, then samples the ack and RECOVER cycles.
  task automatic serve(input int lat, input bit give_data, input logic [7:0] rd,
                       output int low, output logic [NR-1:0] ack_v, output logic [7:0] rdat,
                       output logic err_v, output logic f_wr_n, output logic f_rd_n,
                       output logic [7:0] f_addr, output logic [7:0] f_wdata,
                       output logic ack_after);
    int t;
    t = 0;
    while (hif.hcs_n && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk_val("grant_wait", 32'(t < 30), 32'd1);
    f_wr_n  = hif.hwrite_n;
    f_rd_n  = hif.hread_n;
    f_addr  = hif.haddr;
    f_wdata = hif.hdatain;
    low = 0;
    while (!hif.hcs_n && low < 300) begin
      low++;
      hif.hready_n      = (low >= lat) ? 1'b0 : 1'b1;
      hif.hdataout_en_n = (give_data && (low == lat - 1)) ? 1'b0 : 1'b1;
      if (give_data && (low == lat - 1)) hif.hdataout = rd;
      @(negedge clk);
    end
    ack_v = ack;
    rdat  = rdata;
    err_v = err;
    hif.hready_n      = 1'b1;
    hif.hdataout_en_n = 1'b1;
    @(negedge clk);
    ack_after = (ack != '0) || !hif.hcs_n;
  endtask

  int            low;
  logic [NR-1:0] ack_v;
  logic [7:0]    rdat;
  logic          err_v;
  logic          f_wr_n;
  logic          f_rd_n;
  logic [7:0]    f_addr;
  logic [7:0]    f_wdata;
  logic          ack_after;
  int            hcs_seen;
  logic          ack_seen;
  int            exp_i;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    arst_n            = 1'b0;
    bus_en            = 1'b1;
    req               = 2'b01;
    req_we            = 2'b01;
    req_addr          = {8'h0E, 8'h02};
    req_wdata         = {8'h00, 8'hC2};
    hif.hready_n      = 1'b1;
    hif.hdataout_en_n = 1'b1;
    hif.hdataout      = 8'h00;
    repeat (2) @(negedge clk);

    chk_val("rst_hcs_n",   32'(hif.hcs_n),    32'd1);
    chk_val("rst_hwrite_n",32'(hif.hwrite_n), 32'd1);
    chk_val("rst_hread_n", 32'(hif.hread_n),  32'd1);
    chk_val("rst_haddr",   32'(hif.haddr),    32'h00);
    chk_val("rst_hdatain", 32'(hif.hdatain),  32'h00);
    chk_val("rst_ack",     32'(ack),          32'd0);
    chk_val("rst_rdata",   32'(rdata),        32'h00);
    chk_val("rst_err",     32'(err),          32'd0);
    chk_val("rst_busy",    32'(busy),         32'd0);

    // write 0x02 <= C2 from requester 0
    arst_n = 1'b1;
    serve(3, 1'b0, 8'h00, low, ack_v, rdat, err_v, f_wr_n, f_rd_n, f_addr, f_wdata, ack_after);
    chk_val("wr_low_cycles", 32'(low),     32'd3);
    chk_val("wr_hwrite_n",   32'(f_wr_n),  32'd0);
    chk_val("wr_hread_n",    32'(f_rd_n),  32'd1);
    chk_val("wr_haddr",      32'(f_addr),  32'h02);
    chk_val("wr_hdatain",    32'(f_wdata), 32'hC2);
    chk_val("wr_ack",        32'(ack_v),   32'h1);
    chk_val("wr_rdata",      32'(rdat),    32'h00);
    chk_val("wr_err",        32'(err_v),   32'd0);
    chk_val("wr_recover",    32'(ack_after), 32'd0);
    req = 2'b00;
    @(negedge clk);
    chk_val("wr_busy_low",   32'(busy),    32'd0);

    // read 0x0E from requester 1, data one cycle before ready
    req = 2'b10;
    serve(3, 1'b1, 8'h5A, low, ack_v, rdat, err_v, f_wr_n, f_rd_n, f_addr, f_wdata, ack_after);
    chk_val("rd_low_cycles", 32'(low),    32'd3);
    chk_val("rd_hwrite_n",   32'(f_wr_n), 32'd1);
    chk_val("rd_hread_n",    32'(f_rd_n), 32'd0);
    chk_val("rd_haddr",      32'(f_addr), 32'h0E);
    chk_val("rd_ack",        32'(ack_v),  32'h2);
    chk_val("rd_rdata",      32'(rdat),   32'h5A);
    chk_val("rd_recover",    32'(ack_after), 32'd0);
    req = 2'b00;
    @(negedge clk);
    chk_val("rd_rdata_hold", 32'(rdata),  32'h5A);

    // both requesting continuously: grants alternate 0,1,0,1,0,1
    req_we   = 2'b11;
    req_addr = {8'h21, 8'h20};
    req      = 2'b11;
    for (int i = 0; i < 6; i++) begin
      serve(2, 1'b0, 8'h00, low, ack_v, rdat, err_v, f_wr_n, f_rd_n, f_addr, f_wdata, ack_after);
      exp_i = i % 2;
      chk_val($sformatf("rr_ack_%0d", i),  32'(ack_v),  32'(1 << exp_i));
      chk_val($sformatf("rr_addr_%0d", i), 32'(f_addr), 32'h20 + 32'(exp_i));
    end
    req = 2'b00;

    // read completing on the first ACCESS cycle, no data strobe: rdata 0 despite stale bus
    req_we       = 2'b10;
    req_addr     = {8'h21, 8'h10};
    hif.hdataout = 8'hA5;
    req          = 2'b01;
    serve(1, 1'b0, 8'h00, low, ack_v, rdat, err_v, f_wr_n, f_rd_n, f_addr, f_wdata, ack_after);
    chk_val("fast_low_cycles", 32'(low),   32'd1);
    chk_val("fast_ack",        32'(ack_v), 32'h1);
    chk_val("fast_rdata",      32'(rdat),  32'h00);
    req = 2'b00;

    // bus_en gating
    req_we = 2'b01;
    bus_en = 1'b0;
    req    = 2'b01;
    hcs_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (!hif.hcs_n) hcs_seen++;
    end
    chk_val("gate_no_hcs",  32'(hcs_seen), 32'd0);
    chk_val("gate_no_busy", 32'(busy),     32'd0);
    bus_en = 1'b1;
    @(negedge clk);
    chk_val("gate_grant_next", 32'(hif.hcs_n), 32'd0);
    bus_en = 1'b0;
    serve(3, 1'b0, 8'h00, low, ack_v, rdat, err_v, f_wr_n, f_rd_n, f_addr, f_wdata, ack_after);
    chk_val("gate_mid_low", 32'(low),   32'd3);
    chk_val("gate_mid_ack", 32'(ack_v), 32'h1);
    req    = 2'b00;
    bus_en = 1'b1;

    // MAC never ready on a read from requester 1
    req = 2'b10;
`ifdef MAC_HOST_ARB_TIMEOUT_EN
    serve(100, 1'b0, 8'h00, low, ack_v, rdat, err_v, f_wr_n, f_rd_n, f_addr, f_wdata, ack_after);
    chk_val("to_low_cycles", 32'(low),   32'd16);
    chk_val("to_ack",        32'(ack_v), 32'h2);
    chk_val("to_err",        32'(err_v), 32'd1);
    chk_val("to_rdata",      32'(rdat),  32'hFF);
`else
    serve(40, 1'b0, 8'h00, low, ack_v, rdat, err_v, f_wr_n, f_rd_n, f_addr, f_wdata, ack_after);
    chk_val("slow_low_cycles", 32'(low),   32'd40);
    chk_val("slow_ack",        32'(ack_v), 32'h2);
    chk_val("slow_err",        32'(err_v), 32'd0);
    chk_val("slow_rdata",      32'(rdat),  32'h00);
`endif
    req = 2'b00;

    // ordinary read from requester 0 afterwards
    req_we = 2'b00;
    req    = 2'b01;
    serve(2, 1'b1, 8'h3C, low, ack_v, rdat, err_v, f_wr_n, f_rd_n, f_addr, f_wdata, ack_after);
    chk_val("after_ack",   32'(ack_v), 32'h1);
    chk_val("after_err",   32'(err_v), 32'd0);
    chk_val("after_rdata", 32'(rdat),  32'h3C);
    req = 2'b00;

    // reset in the middle of a write from requester 1
    req_we = 2'b11;
    req    = 2'b10;
    hcs_seen = 0;
    while (hif.hcs_n && hcs_seen < 30) begin
      @(negedge clk);
      hcs_seen++;
    end
    chk_val("mid_rst_granted", 32'(hif.hcs_n), 32'd0);
    @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk_val("mid_rst_hcs_n",    32'(hif.hcs_n),    32'd1);
    chk_val("mid_rst_hwrite_n", 32'(hif.hwrite_n), 32'd1);
    chk_val("mid_rst_hread_n",  32'(hif.hread_n),  32'd1);
    chk_val("mid_rst_busy",     32'(busy),         32'd0);
    req = 2'b11;
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack != '0) ack_seen = 1'b1;
    end
    chk_val("mid_rst_no_ack", 32'(ack_seen), 32'd0);
    arst_n = 1'b1;
    serve(2, 1'b0, 8'h00, low, ack_v, rdat, err_v, f_wr_n, f_rd_n, f_addr, f_wdata, ack_after);
    chk_val("post_rst_ack0", 32'(ack_v), 32'h1);
    req = 2'b00;
    repeat (3) @(negedge clk);

    chk_val("single_ack", 32'(multi_ack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
